// File: rtl/hash_rate_bcd_formatter_pkg.sv
// Shared types and constants for the hash-rate BCD formatter.
// Optional feature: define HASH_RATE_ROUND_EN to round half-up instead of truncating.
package hash_rate_bcd_formatter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StFormat = 2'd2
    } state_e;

    localparam int unsigned BCD_DIGITS = 5;

    localparam logic [2:0] DP_NONE   = 3'b000;
    localparam logic [2:0] DP_K_MID  = 3'b010;
    localparam logic [2:0] DP_K_HIGH = 3'b100;

    // Lower bounds of the "d3.d2d1" and "d4d3.d2" display ranges.
    localparam int unsigned RANGE_K_LOW  = 1000;
    localparam int unsigned RANGE_K_HIGH = 10000;

`ifdef HASH_RATE_ROUND_EN
    // Increment a 3-digit BCD window; bit 12 is the decimal carry out.
    function automatic logic [12:0] bcd3_inc(input logic [11:0] win);
        logic [12:0] res;
        logic        carry;
        res   = '0;
        carry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (carry && win[4*i+:4] == 4'd9) begin
                res[4*i+:4] = 4'd0;
            end else if (carry) begin
                res[4*i+:4] = win[4*i+:4] + 4'd1;
                carry       = 1'b0;
            end else begin
                res[4*i+:4] = win[4*i+:4];
            end
        end
        res[12] = carry;
        return res;
    endfunction
`endif

endpackage

// File: rtl/hash_rate_bcd_formatter_if.sv
// Value input handshake plus formatted digit output bundle.
interface hash_rate_bcd_formatter_if #(
    parameter int unsigned VALUE_W = 16
);
    logic [VALUE_W-1:0] value;
    logic               value_valid;
    logic               value_ready;
    logic [11:0]        data;
    logic [2:0]         dp;
    logic               data_valid;

    // Producer of values / consumer of formatted digits.
    modport master (
        output value, value_valid,
        input  value_ready, data, dp, data_valid
    );

    // The formatter itself.
    modport slave (
        input  value, value_valid,
        output value_ready, data, dp, data_valid
    );
endinterface

// File: rtl/hash_rate_bcd_formatter_bcd_digit_adj.sv
// Double-dabble digit corrector: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);
    // Correction is a plain 4-bit add; no carry leaves the digit.
    always_comb begin
        corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
endmodule

// File: rtl/hash_rate_bcd_formatter.sv
// Sequential binary-to-BCD converter and 3-digit scaler for the seven-segment display.
// Optional feature: define HASH_RATE_ROUND_EN to round half-up on the first dropped digit.
module hash_rate_bcd_formatter
    import hash_rate_bcd_formatter_pkg::*;
#(
    parameter int unsigned VALUE_W = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    hash_rate_bcd_formatter_if.slave bus
);
    localparam int unsigned ITERS = VALUE_W;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] shift_q;
    logic [VALUE_W-1:0] value_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [11:0]        data_q, fmt_data;
    logic [2:0]         dp_q, fmt_dp;
    logic               valid_q;
    logic               transfer;
`ifdef HASH_RATE_ROUND_EN
    logic [12:0]        inc;
`endif

    assign transfer = bus.value_valid && bus.value_ready;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (bcd_q[4*i+:4]),
            .corrected (bcd_adj[4*i+:4])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (transfer) state_d = StShift;
            StShift:  if (cnt_q == CNT_W'(ITERS - 1)) state_d = StFormat;
            StFormat: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.value_ready = (state_q == StIdle);
    end

    // Capture on transfer, then one corrected shift per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            value_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (transfer) begin
            shift_q <= bus.value;
            value_q <= bus.value;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == StShift) begin
            {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
            cnt_q            <= cnt_q + CNT_W'(1);
        end
    end

    // Pick the 3-digit window and decimal point from the finished BCD value.
    always_comb begin
        fmt_data = bcd_q[11:0];
        fmt_dp   = DP_NONE;
`ifdef HASH_RATE_ROUND_EN
        inc      = '0;
`endif
        if (32'(value_q) >= RANGE_K_HIGH) begin
            fmt_data = bcd_q[19:8];
            fmt_dp   = DP_K_MID;
`ifdef HASH_RATE_ROUND_EN
            // Max window here is 655, so the increment never carries out.
            if (bcd_q[7:4] >= 4'd5) begin
                inc      = bcd3_inc(bcd_q[19:8]);
                fmt_data = inc[11:0];
            end
`endif
        end else if (32'(value_q) >= RANGE_K_LOW) begin
            fmt_data = bcd_q[15:4];
            fmt_dp   = DP_K_HIGH;
`ifdef HASH_RATE_ROUND_EN
            if (bcd_q[3:0] >= 4'd5) begin
                inc = bcd3_inc(bcd_q[15:4]);
                if (inc[12]) begin
                    // 9995..9999 rounds to 10.0k.
                    fmt_data = 12'h100;
                    fmt_dp   = DP_K_MID;
                end else begin
                    fmt_data = inc[11:0];
                end
            end
`endif
        end
    end

    // Output registers: update and pulse valid in FORMAT, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 12'h000;
            dp_q    <= DP_NONE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == StFormat);
            if (state_q == StFormat) begin
                data_q <= fmt_data;
                dp_q   <= fmt_dp;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.dp         = dp_q;
    assign bus.data_valid = valid_q;

endmodule
